// File: rtl/vdp_color_mixer.sv
// VDP pixel output stage: priority/border resolution, Game Gear CRAM lookup and
// the CPU-side latched 16-bit CRAM write port.
module vdp_color_mixer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] bg_color,
  input  logic       bg_priority,
  input  logic [3:0] spr_color,
  input  logic       in_active,
  input  logic       in_mask,
  input  logic [3:0] border_color,
  input  logic       cram_we,
  input  logic [5:0] cram_a,
  input  logic [7:0] cram_d,
  output logic [7:0] cram_q,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       de
);

  localparam int unsigned EntryW     = 12;
  localparam int unsigned NumEntries = 32;
  localparam int unsigned IdxW       = 5;
  localparam int unsigned ChanW      = 4;
  localparam int unsigned ByteW      = 8;

  logic [EntryW-1:0] mem_q [NumEntries];
  logic [EntryW-1:0] mem_d [NumEntries];
  logic [ByteW-1:0]  latch_q, latch_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              act_q, act_d;
  logic [ChanW-1:0]  red_q, red_d;
  logic [ChanW-1:0]  green_q, green_d;
  logic [ChanW-1:0]  blue_q, blue_d;
  logic              de_q, de_d;
  logic [ByteW-1:0]  cram_rd_q, cram_rd_d;

  logic [EntryW-1:0] pix_entry;
  logic [EntryW-1:0] cpu_entry;
  logic              bg_opaque;
  logic              bg_lsb_unused;

  // The even-byte bit of the background address carries no information.
  assign bg_lsb_unused = bg_color[0];

  // CPU write port: even byte fills the latch, odd byte commits a whole entry.
  always_comb begin
    latch_d = latch_q;
    mem_d   = mem_q;
    if (cram_we) begin
      if (!cram_a[0]) begin
        latch_d = cram_d;
      end else begin
        mem_d[cram_a[5:1]] = {cram_d[3:0], latch_q};
      end
    end
  end

  // Stage 1: resolve which palette entry this pixel shows.
  always_comb begin
    bg_opaque = (bg_color[4:1] != 4'd0);
    act_d     = in_active;
    idx_d     = bg_color[5:1];
    if (!in_active || in_mask) begin
      idx_d = {1'b1, border_color};
    end else if ((spr_color != 4'd0) && !(bg_priority && bg_opaque)) begin
      idx_d = {1'b1, spr_color};
    end
  end

  // Stage 2 and CPU readback read committed CRAM state only (pre-commit this edge).
  always_comb begin
    pix_entry = mem_q[idx_q];
    cpu_entry = mem_q[cram_a[5:1]];
    red_d     = pix_entry[3:0];
    green_d   = pix_entry[7:4];
    blue_d    = pix_entry[11:8];
    de_d      = act_q;
    if (cram_a[0]) begin
      cram_rd_d = {4'h0, cpu_entry[11:8]};
    end else begin
      cram_rd_d = cpu_entry[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumEntries; i++) begin
        mem_q[i] <= '0;
      end
      latch_q   <= '0;
      idx_q     <= '0;
      act_q     <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      de_q      <= 1'b0;
      cram_rd_q <= '0;
    end else begin
      mem_q     <= mem_d;
      latch_q   <= latch_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      de_q      <= de_d;
      cram_rd_q <= cram_rd_d;
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign blue   = blue_q;
  assign de     = de_q;
  assign cram_q = cram_rd_q;

endmodule

// File: tb/tb_vdp_color_mixer.sv
// Self-checking bench for vdp_color_mixer: directed scenarios plus a randomized
// stream checked against a palette/priority reference model.
module tb_vdp_color_mixer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] bg_color = '0;
  logic       bg_priority = 1'b0;
  logic [3:0] spr_color = '0;
  logic       in_active = 1'b0;
  logic       in_mask = 1'b0;
  logic [3:0] border_color = '0;
  logic       cram_we = 1'b0;
  logic [5:0] cram_a = '0;
  logic [7:0] cram_d = '0;
  logic [7:0] cram_q;
  logic [3:0] red, green, blue;
  logic       de;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [11:0] m_mem [32];
  logic [7:0]  m_latch;
  int          pend_idx[$];
  bit          pend_act[$];

  vdp_color_mixer dut (
    .clk(clk), .rst_n(rst_n), .bg_color(bg_color), .bg_priority(bg_priority),
    .spr_color(spr_color), .in_active(in_active), .in_mask(in_mask),
    .border_color(border_color), .cram_we(cram_we), .cram_a(cram_a),
    .cram_d(cram_d), .cram_q(cram_q), .red(red), .green(green), .blue(blue),
    .de(de)
  );

  always #5 clk = ~clk;

  function automatic int pick_entry();
    if (!in_active || in_mask) return 16 + int'(border_color);
    if (spr_color != 0 && !(bg_priority && bg_color[4:1] != 0)) return 16 + int'(spr_color);
    return int'(bg_color) / 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 12'h000;
    m_latch = 8'h00;
    pend_idx.delete();
    pend_act.delete();
    pend_idx.push_back(0);
    pend_act.push_back(1'b0);
  endtask

  // One clock: advance model, then check every output 1 time unit after the edge.
  task automatic step();
    int          sel, rd;
    bit          sel_act, rd_act;
    logic [11:0] exp_rgb, cpu_e;
    logic [7:0]  exp_cq;
    sel     = pick_entry();
    sel_act = in_active;
    @(posedge clk);
    rd     = pend_idx.pop_front();
    rd_act = pend_act.pop_front();
    exp_rgb = m_mem[rd];
    cpu_e   = m_mem[int'(cram_a) / 2];
    exp_cq  = cram_a[0] ? {4'h0, cpu_e[11:8]} : cpu_e[7:0];
    if (cram_we) begin
      if (cram_a[0]) m_mem[int'(cram_a) / 2] = {cram_d[3:0], m_latch};
      else m_latch = cram_d;
    end
    pend_idx.push_back(sel);
    pend_act.push_back(sel_act);
    #1;
    checks++;
    if ({blue, green, red} !== exp_rgb) begin
      failures++;
      $display("FAIL pixel_rgb t=%0t got=%h expected=%h (entry %0d)", $time, {blue, green, red}, exp_rgb, rd);
    end
    checks++;
    if (de !== rd_act) begin
      failures++;
      $display("FAIL pixel_de t=%0t got=%b expected=%b", $time, de, rd_act);
    end
    checks++;
    if (cram_q !== exp_cq) begin
      failures++;
      $display("FAIL cram_q t=%0t a=%h got=%h expected=%h", $time, cram_a, cram_q, exp_cq);
    end
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [7:0] d);
    cram_we = 1'b1; cram_a = a; cram_d = d;
    step();
    cram_we = 1'b0;
  endtask

  task automatic set_pixel(input logic [5:0] bg, input logic pri, input logic [3:0] spr,
                           input logic act, input logic msk);
    bg_color = bg; bg_priority = pri; spr_color = spr; in_active = act; in_mask = msk;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({blue, green, red, de, cram_q} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", {blue, green, red, de, cram_q});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_pair();
    cpu_write(6'h02, 8'h5A);
    cpu_write(6'h03, 8'h0C);
    cram_a = 6'h02; step(); step();
    checks++;
    if (cram_q !== 8'h5A) begin
      failures++; $display("FAIL wp_even got=%h expected=5a", cram_q);
    end
    cram_a = 6'h03; step();
    checks++;
    if (cram_q !== 8'h0C) begin
      failures++; $display("FAIL wp_odd got=%h expected=0c", cram_q);
    end
    cpu_write(6'h04, 8'hFF);
    cram_a = 6'h04; step();
    checks++;
    if (cram_q !== 8'h00) begin
      failures++; $display("FAIL even_only got=%h expected=00", cram_q);
    end
  endtask

  task automatic test_pipeline();
    cpu_write(6'h0A, 8'h23);
    cpu_write(6'h0B, 8'h01);
    set_pixel(6'h0A, 1'b0, 4'd0, 1'b1, 1'b0);
    step();
    set_pixel(6'h02, 1'b0, 4'd0, 1'b1, 1'b0);
    step();
    checks++;
    if ({red, green, blue, de} !== {4'd3, 4'd2, 4'd1, 1'b1}) begin
      failures++; $display("FAIL latency2 got=%h expected=%h", {red, green, blue, de}, {4'd3, 4'd2, 4'd1, 1'b1});
    end
    for (int i = 0; i < 8; i++) begin
      set_pixel(6'((i * 6) & 6'h3E), 1'b0, 4'd0, 1'b1, 1'b0);
      step();
    end
  endtask

  task automatic test_priority();
    cpu_write(6'h26, 8'hB4);  // entry 19 = 0x7B4
    cpu_write(6'h27, 8'h07);
    cpu_write(6'h2E, 8'h9C);  // entry 23 = 0x59C
    cpu_write(6'h2F, 8'h05);
    set_pixel(6'h0A, 1'b0, 4'd3, 1'b1, 1'b0); step();
    set_pixel(6'h0A, 1'b1, 4'd3, 1'b1, 1'b0); step();
    checks++;
    if ({blue, green, red} !== 12'h7B4) begin
      failures++; $display("FAIL spr_over_bg got=%h expected=7b4", {blue, green, red});
    end
    set_pixel(6'h00, 1'b1, 4'd3, 1'b1, 1'b0); step();
    checks++;
    if ({blue, green, red} !== 12'h123) begin
      failures++; $display("FAIL bg_priority got=%h expected=123", {blue, green, red});
    end
    border_color = 4'd7;
    set_pixel(6'h0A, 1'b0, 4'd3, 1'b0, 1'b0); step();
    checks++;
    if ({blue, green, red} !== 12'h7B4) begin
      failures++; $display("FAIL bg0_no_hide got=%h expected=7b4", {blue, green, red});
    end
    set_pixel(6'h0A, 1'b0, 4'd3, 1'b1, 1'b1); step();
    checks++;
    if ({blue, green, red, de} !== {12'h59C, 1'b0}) begin
      failures++; $display("FAIL border_inactive got=%h expected=%h", {blue, green, red, de}, {12'h59C, 1'b0});
    end
    step();
    checks++;
    if ({blue, green, red, de} !== {12'h59C, 1'b1}) begin
      failures++; $display("FAIL border_mask got=%h expected=%h", {blue, green, red, de}, {12'h59C, 1'b1});
    end
  endtask

  task automatic test_collision();
    set_pixel(6'h0A, 1'b0, 4'd0, 1'b1, 1'b0);
    cpu_write(6'h0A, 8'hFF);
    cpu_write(6'h0B, 8'h0F);
    checks++;
    if ({blue, green, red} !== 12'h123) begin
      failures++; $display("FAIL collision_old got=%h expected=123", {blue, green, red});
    end
    step();
    checks++;
    if ({blue, green, red} !== 12'hFFF) begin
      failures++; $display("FAIL collision_new got=%h expected=fff", {blue, green, red});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_pixel(6'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 5) == 0));
      border_color = 4'($urandom);
      cram_we = ($urandom_range(0, 2) == 0);
      cram_a  = 6'($urandom);
      cram_d  = 8'($urandom);
      step();
    end
    cram_we = 1'b0;
  endtask

  task automatic test_reset_midstream();
    set_pixel(6'h0A, 1'b0, 4'd0, 1'b1, 1'b0);
    cpu_write(6'h0A, 8'hFF);
    cpu_write(6'h0B, 8'h0F);
    cpu_write(6'h02, 8'hAB);
    cram_a = 6'h0A;
    step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({blue, green, red, de, cram_q} !== 21'h0) begin
      failures++; $display("FAIL async_reset got=%h expected=0", {blue, green, red, de, cram_q});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_pixel(6'h02, 1'b0, 4'd0, 1'b1, 1'b0);
    cpu_write(6'h03, 8'h0F);
    cram_a = 6'h02; step();
    checks++;
    if (cram_q !== 8'h00) begin
      failures++; $display("FAIL post_reset_even got=%h expected=00", cram_q);
    end
    cram_a = 6'h03; step();
    checks++;
    if (cram_q !== 8'h0F) begin
      failures++; $display("FAIL post_reset_odd got=%h expected=0f", cram_q);
    end
    checks++;
    if ({blue, green, red} !== 12'hF00) begin
      failures++; $display("FAIL post_reset_pixel got=%h expected=f00", {blue, green, red});
    end
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_pipeline();
    test_priority();
    test_collision();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
